// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: latches bus writes and scans 8 hex nibbles onto a common-anode 7-seg display
// Optional SEG7_BLANK_LEADING_ZERO_EN blanks leading zero digits (digit 0 always shown).
module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        seg7_we,
  input  logic [31:0] cpuseg7_data,
  input  logic [31:0] alt_data,
  input  logic        disp_mode,
  output logic [7:0]  disp_an,
  output logic [7:0]  disp_seg
);
  localparam int CW = $clog2(SCAN_DIV);
  // enc(n) lives at bits [8n+7:8n], dp off
  localparam logic [127:0] ENC = {8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
                                  8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0};
  logic [31:0]   data_reg;
  logic [31:0]   src;
  logic [CW-1:0] div_cnt;
  logic [2:0]    dig_idx;
  logic [2:0]    nxt_idx;
  logic [3:0]    nib;
  logic          tick;
  logic          blank;
  assign tick    = div_cnt == CW'(SCAN_DIV - 1);
  assign nxt_idx = dig_idx + 3'd1;
  assign src     = disp_mode ? alt_data : data_reg;
  assign nib     = src[{nxt_idx, 2'b00} +: 4];
`ifdef SEG7_BLANK_LEADING_ZERO_EN
  assign blank = (src >> {nxt_idx, 2'b00}) == 32'd0 && nxt_idx != 3'd0;
`else
  assign blank = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg <= '0;
      div_cnt  <= '0;
      dig_idx  <= '0;
      disp_an  <= 8'hFF;
      disp_seg <= 8'hFF;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      if (seg7_we) data_reg <= cpuseg7_data;
      if (tick) begin
        dig_idx  <= nxt_idx;
        disp_an  <= ~(8'b1 << nxt_idx);
        disp_seg <= blank ? 8'hFF : ENC[{nib, 3'b000} +: 8];
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb_seg7_scan_ctrl: directed scoreboard bench for seg7_scan_ctrl with SCAN_DIV=4
module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        seg7_we;
  logic [31:0] cpuseg7_data;
  logic [31:0] alt_data;
  logic        disp_mode;
  logic [7:0]  disp_an;
  logic [7:0]  disp_seg;
  int          errors = 0;
  int          checks = 0;
  int          ph;
  logic [2:0]  m_idx;
  logic [31:0] m_data;
  logic [15:0] last;
  logic [15:0] sb[$];

  seg7_scan_ctrl #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .seg7_we(seg7_we), .cpuseg7_data(cpuseg7_data),
    .alt_data(alt_data), .disp_mode(disp_mode), .disp_an(disp_an), .disp_seg(disp_seg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] enc(input logic [3:0] n);
    case (n)
      4'h0: enc = 8'hC0; 4'h1: enc = 8'hF9; 4'h2: enc = 8'hA4; 4'h3: enc = 8'hB0;
      4'h4: enc = 8'h99; 4'h5: enc = 8'h92; 4'h6: enc = 8'h82; 4'h7: enc = 8'hF8;
      4'h8: enc = 8'h80; 4'h9: enc = 8'h90; 4'hA: enc = 8'h88; 4'hB: enc = 8'h83;
      4'hC: enc = 8'hC6; 4'hD: enc = 8'hA1; 4'hE: enc = 8'h86; default: enc = 8'h8E;
    endcase
  endfunction

  function automatic logic [15:0] exp_of(input logic [2:0] i, input logic [31:0] s);
    logic blank;
    blank = 1'b0;
`ifdef SEG7_BLANK_LEADING_ZERO_EN
    blank = (i != 3'd0);
    for (int k = int'(i); k < 8; k++) if (s[4*k +: 4] != 4'h0) blank = 1'b0;
`endif
    exp_of = {~(8'b1 << i), blank ? 8'hFF : enc(s[4*i +: 4])};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic edge1();
    logic t;
    t = (ph == 3);
    @(posedge clk);
    #1;
    if (rst) begin
      ph = 0; m_idx = 3'd0; m_data = 32'd0;
    end else begin
      if (seg7_we) m_data = cpuseg7_data;
      ph = t ? 0 : ph + 1;
      if (t) m_idx = m_idx + 3'd1;
    end
  endtask

  task automatic run_to_tick();
    while (ph != 3) edge1();
    edge1();
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e;
    if (sb.size() == 0) begin
      checks++; errors++;
      $error("FAIL %s_empty: got empty expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_an"}, disp_an, e[15:8]);
      check({tag, "_seg"}, disp_seg, e[7:0]);
      last = e;
    end
  endtask

  task automatic slot(input string tag);
    while (ph != 3) edge1();
    sb.push_back(exp_of(m_idx + 3'd1, disp_mode ? alt_data : m_data));
    edge1();
    pop_check(tag);
  endtask

  task automatic write(input logic [31:0] d);
    seg7_we = 1'b1; cpuseg7_data = d;
    edge1();
    seg7_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; seg7_we = 1'b0; cpuseg7_data = '0; alt_data = '0; disp_mode = 1'b0;
    ph = 0; m_idx = 3'd0; m_data = '0; last = '0;
    repeat (3) edge1();
    check("rst_an", disp_an, 8'hFF);
    check("rst_seg", disp_seg, 8'hFF);
    rst = 1'b0;
    repeat (3) edge1();
    check("pre_an", disp_an, 8'hFF);
    check("pre_seg", disp_seg, 8'hFF);
    slot("first");

    write(32'h7654_3210);
    for (int k = 0; k < 8; k++) sb.push_back(exp_of(m_idx + 3'(k + 1), m_data));
    for (int k = 0; k < 8; k++) begin
      run_to_tick();
      pop_check("walk");
    end

    while (ph != 3) edge1();
    sb.push_back(exp_of(m_idx + 3'd1, m_data));
    seg7_we = 1'b1; cpuseg7_data = 32'hFFFF_FFFF;
    edge1();
    seg7_we = 1'b0;
    pop_check("wr_tick_old");
    slot("wr_tick_new0");
    slot("wr_tick_new1");

    write(32'h1111_1111);
    slot("mode0");
    edge1();
    disp_mode = 1'b1; alt_data = 32'hABCD_EF00;
    edge1();
    check("hold_an", disp_an, last[15:8]);
    check("hold_seg", disp_seg, last[7:0]);
    slot("mode1");
    slot("mode1b");
    disp_mode = 1'b0;
    slot("mode_back");

    while (m_idx != 3'd5) edge1();
    edge1();
    rst = 1'b1; seg7_we = 1'b1; cpuseg7_data = 32'h1234_5678;
    edge1();
    rst = 1'b0; seg7_we = 1'b0;
    check("midrst_an", disp_an, 8'hFF);
    check("midrst_seg", disp_seg, 8'hFF);
    repeat (3) edge1();
    check("restart_pre_an", disp_an, 8'hFF);
    slot("restart1");
    slot("restart2");

    write(32'h0000_00A5);
    for (int k = 0; k < 8; k++) slot("lz");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
